// File: rtl/alu64_add_and_or_unit.sv
// alu64_add_and_or_unit: registered ripple-carry ADD / AND / OR slice with op-selected result and zero flag
module alu64_add_and_or_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] and_ab,
    output logic [WIDTH-1:0] or_ab,
    output logic             zero
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_w;
    logic             valid_q, valid_d, cout_q, cout_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] sum_q, sum_d, and_q, and_d, or_q, or_d;

    assign carry[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_w[i]   = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    always_comb begin
        valid_d = in_valid;
        op_d    = in_valid ? op           : op_q;
        sum_d   = in_valid ? sum_w        : sum_q;
        cout_d  = in_valid ? carry[WIDTH] : cout_q;
        and_d   = in_valid ? a & b        : and_q;
        or_d    = in_valid ? a | b        : or_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            op_q    <= 2'b00;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            and_q   <= '0;
            or_q    <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            and_q   <= and_d;
            or_q    <= or_d;
        end
    end

    // reserved op 11 yields all-zero so no output is ever undefined
    assign result    = op_q == 2'b00 ? sum_q :
                       op_q == 2'b01 ? and_q :
                       op_q == 2'b10 ? or_q  : '0;
    assign zero      = result == '0;
    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign and_ab    = and_q;
    assign or_ab     = or_q;
endmodule

// File: tb/tb_alu64_add_and_or_unit.sv
// tb_alu64_add_and_or_unit: directed vectors with a scoreboard queue checked by a decoupled monitor
module tb_alu64_add_and_or_unit;
    localparam int W = 64;
    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] s;
        logic         c;
        logic [W-1:0] an;
        logic [W-1:0] o;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, in_valid, cin, out_valid, cout, zero;
    logic [W-1:0] a, b, result, sum, and_ab, or_ab;
    logic [1:0]   op;
    exp_t         q[$];
    int           errors = 0, checks = 0, pushed = 0, popped = 0;

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

    alu64_add_and_or_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(out_valid), .result(result), .sum(sum), .cout(cout),
        .and_ab(and_ab), .or_ab(or_ab), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic state(input string n, input logic v, input exp_t e);
        chk({n, ".out_valid"}, W'(out_valid), W'(v));
        chk({n, ".result"}, result, e.r);
        chk({n, ".sum"}, sum, e.s);
        chk({n, ".cout"}, W'(cout), W'(e.c));
        chk({n, ".and_ab"}, and_ab, e.an);
        chk({n, ".or_ab"}, or_ab, e.o);
        chk({n, ".zero"}, W'(zero), W'(e.z));
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic [1:0] to, input exp_t e);
        a = ta; b = tb; cin = tc; op = to; in_valid = 1'b1;
        q.push_back(e);
        pushed++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 (scoreboard empty)");
            end else begin
                exp_t e;
                e = q.pop_front();
                popped++;
                state("scoreboard", 1'b1, e);
            end
        end
    end

    initial begin
        exp_t zr;
        zr = '{r: '0, s: '0, c: 1'b0, an: '0, o: '0, z: 1'b1};
        reset = 1'b1; in_valid = 1'b1; a = 5; b = 3; cin = 1'b0; op = 2'b00;
        repeat (2) @(posedge clk);
        #1 state("reset", 1'b0, zr);
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1 state("post_reset", 1'b0, zr);

        issue(ONES, 1, 0, 2'b00, '{r: 0, s: 0, c: 1, an: 1, o: ONES, z: 1});
        issue(ONES, 1, 1, 2'b00, '{r: 1, s: 1, c: 1, an: 1, o: ONES, z: 0});
        issue(5, 3, 1, 2'b00, '{r: 9, s: 9, c: 0, an: 1, o: 7, z: 0});
        issue(MSB, MSB, 0, 2'b00, '{r: 0, s: 0, c: 1, an: MSB, o: MSB, z: 1});
        issue(64'hF0F0, 64'hFF00, 0, 2'b01, '{r: 64'hF000, s: 64'h1EFF0, c: 0, an: 64'hF000, o: 64'hFFF0, z: 0});
        issue(64'hF0F0, 64'hFF00, 0, 2'b10, '{r: 64'hFFF0, s: 64'h1EFF0, c: 0, an: 64'hF000, o: 64'hFFF0, z: 0});
        issue(5, 3, 1, 2'b00, '{r: 9, s: 9, c: 0, an: 1, o: 7, z: 0});

        a = 7; b = 7; cin = 1'b0; op = 2'b01;
        @(posedge clk);
        #1 state("hold", 1'b0, '{r: 9, s: 9, c: 0, an: 1, o: 7, z: 0});
        issue(5, 3, 1, 2'b11, '{r: 0, s: 9, c: 0, an: 1, o: 7, z: 1});

        issue(1, 64'h10, 0, 2'b00, '{r: 64'h11, s: 64'h11, c: 0, an: 0, o: 64'h11, z: 0});
        issue(2, 64'h10, 0, 2'b00, '{r: 64'h12, s: 64'h12, c: 0, an: 0, o: 64'h12, z: 0});
        issue(3, 64'h10, 0, 2'b00, '{r: 64'h13, s: 64'h13, c: 0, an: 0, o: 64'h13, z: 0});
        a = 4; reset = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; in_valid = 1'b0;
        state("mid_reset", 1'b0, zr);
        issue(5, 64'h10, 0, 2'b00, '{r: 64'h15, s: 64'h15, c: 0, an: 0, o: 64'h15, z: 0});

        repeat (4) @(posedge clk);
        chk("drain_count", W'(popped), W'(pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu64_add_and_or_unit.md
Name: alu64_add_and_or_unit

Overview:
- Registered 64-bit logic/arithmetic slice: ripple-carry adder with carry-in/carry-out, bitwise AND and bitwise OR.
- Serves as the ADD/AND/OR datapath of the CPU execution stage.
- All three results are computed in parallel every accepted cycle and registered.
- `op` selects which one drives `result`.

Parameters:
- WIDTH, 64, operand/result width in bits. Only 64 is required to be verified; the RTL must stay generic.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands/op accepted on the rising clk edge when high
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  adder carry-in
- op  input  2  select: 00 ADD, 01 AND, 10 OR, 11 reserved
- out_valid  output  1  high for one cycle after each accepted input
- result  output  WIDTH  selected registered result
- sum  output  WIDTH  registered a+b+cin (low WIDTH bits)
- cout  output  1  registered carry out of bit WIDTH-1
- and_ab  output  WIDTH  registered a & b
- or_ab  output  WIDTH  registered a | b
- zero  output  1  high when result == 0

Behaviour:
- One clock domain, rising edge. Reset is synchronous and active-high: sampled on the rising clk edge, it has priority over in_valid.
- Reset values:
  - out_valid = 0
  - result, sum, and_ab, or_ab = 0
  - cout = 0
  - zero = 1, because it is derived from result.
- Latency: exactly 1 cycle.
  - Inputs sampled at edge N with in_valid=1 appear on all outputs after edge N.
  - out_valid = 1 during the following cycle.
- Throughput: one operation per cycle; back-to-back in_valid accepted every cycle with no bubbles.
- in_valid = 0 at an edge:
  - out_valid goes 0.
  - result, sum, cout, and_ab, or_ab, zero hold their previous values.
- Adder:
  - sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full-precision sum. Operands are treated as unsigned.
  - Structure is a chain of 1-bit full adders. Bit i: s = a^b^c, c_next = (a&b)|(a&c)|(b&c), with c0 = cin.
  - cout is registered every accepted cycle regardless of op.
- and_ab = a & b and or_ab = a | b, bitwise over the full width, registered every accepted cycle regardless of op.
- result mux on the registered op:
  - 00 → sum; 01 → and_ab; 10 → or_ab.
  - 11 → all-zero. out_valid still asserts for op=11.
- zero is combinational from the registered result (no extra latency).
- No overflow flag. Signed overflow is not reported.
- Reset during the cycle an operation is accepted: reset wins, that operation is discarded, and out_valid stays 0 in the next cycle.
- No X propagation from unused op encodings: every output is fully defined in every case.

Test Plan:
- Reset: assert reset for 2 edges with in_valid=1, a=5, b=3 → out_valid=0, result=0, sum=0, cout=0, zero=1. Release reset → values stay at reset until the next accepted op.
- ADD wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, op=00 → next cycle sum=0, cout=1, result=0, zero=1, out_valid=1. Same operands with cin=1 → sum=1, cout=1.
- ADD with carry-in: a=5, b=3, cin=1, op=00 → sum=9, cout=0, result=9, zero=0. Also a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000, cin=0 → sum=0, cout=1.
- Logic ops, back-to-back cycles, a=0x0000_0000_0000_F0F0, b=0x0000_0000_0000_FF00:
  - op=01 → result=0xF000.
  - op=10 → result=0xFFF0.
  - In both cycles and_ab=0xF000, or_ab=0xFFF0, sum=0x1_EFF0, and out_valid stays high both cycles.
- Hold/reserved:
  - After an accepted ADD giving 9, drop in_valid and change a/b → outputs hold 9 and out_valid=0.
  - Then op=11 with in_valid=1 → result=0, zero=1, out_valid=1.
- Reset mid-stream: in_valid=1 each cycle with increasing a; assert reset for one edge → the next cycle out_valid=0 and all outputs are zero. The operation presented on the following edge completes normally.
